sampler_rr_arbiter: RTL and testbench
=====================================

// Module: sampler_rr_arbiter
// PURPOSE
//   Fast-domain scheduler sharing one data_sampler CDC path among NUM_REQ requesters.
//   Round-robin arbitration; issues one single-cycle sample request to the sampler,
//   then a hold-off of HOLD_CYC cycles covering the full req/ack round trip before the
//   next issue. Sits between the fast-domain producers and the sampler's valid_i/data_i.
// PARAMETERS
//   NUM_REQ   4   number of requesters, >=1
//   DATA_W    32  payload width, matches the sampler's DATA_W
//   HOLD_CYC  16  fast_clk cycles of hold-off after issue, >=2; sized > sampler round trip
// PORTS
//   fast_clk     in   1               single clock; all logic on posedge
//   rst          in   1               synchronous, active-low reset
//   req_valid_i  in   NUM_REQ         per-requester valid; held until matching ready
//   req_data_i   in   NUM_REQ*DATA_W  flat payload; slice i = [i*DATA_W +: DATA_W]
//   req_ready_o  out  NUM_REQ         one-hot, 1-cycle accept pulse to the winner
//   smp_valid_o  out  1               1-cycle pulse -> sampler valid_i
//   smp_data_o   out  DATA_W          -> sampler data_i; stable from ISSUE through HOLD
//   smp_src_o    out  IDX_W           index of the last granted requester (IDX_W=max(1,$clog2(NUM_REQ)))
//   busy_o       out  1               1 in ISSUE/HOLD
// BEHAVIOUR
//   Reset (rst==0 at a posedge): state IDLE, rr_ptr=0, hold_cnt=0, all outputs 0.
//   Reset mid-operation aborts any issue/hold immediately; no pending grant survives.
//   FSM: IDLE -> ISSUE -> HOLD -> IDLE.
//   IDLE: if any req_valid_i at cycle T, pick the first set bit scanning rr_ptr,
//     rr_ptr+1, ... mod NUM_REQ. Capture its data into smp_data_o and its index into
//     smp_src_o at T. Go to ISSUE at T+1. No request: stay in IDLE; outputs hold.
//   ISSUE (1 cycle, T+1): smp_valid_o=1, req_ready_o[win]=1.
//     rr_ptr <= (win==NUM_REQ-1) ? 0 : win+1. Load hold_cnt=HOLD_CYC-1. Go to HOLD.
//   HOLD: decrement hold_cnt each cycle. Leave at hold_cnt==0 (HOLD_CYC cycles total).
//     Requests are ignored while in HOLD.
//   Issue-to-issue period: HOLD_CYC+2 cycles (IDLE arbitration cycle included).
//   Requester protocol: valid and data held stable from assertion until ready.
//     Deasserting earlier is a protocol violation; the winner is latched in IDLE regardless.
//   Simultaneous requests: exactly one grant per issue; strict rotation when all are
//     valid (0,1,2,3,0,...). NUM_REQ==1: the pointer stays 0.
//   smp_data_o/smp_src_o change only on the IDLE->ISSUE transition.
// CONFIGURATION
//   SAMPLER_ARB_BUSY_EN defined: adds input smp_busy_i (1 bit; the sampler's fast-side
//     hold state). HOLD exits only when hold_cnt==0 AND smp_busy_i==0; otherwise it stays
//     in HOLD with hold_cnt at 0.
//   Undefined: port is absent; HOLD exit depends on hold_cnt only.
// STRUCTURE
//   sampler_arb_pkg: state enum arb_state_e {ST_ARB_IDLE, ST_ARB_ISSUE, ST_ARB_HOLD};
//     function idx_w(n) for the index width.
//   Sub-module rr_prio_pick: combinational rotate-priority picker
//     (req vector + pointer -> one-hot and index). Instantiated once.
//   Top level: FSM, rr_ptr, hold_cnt ($clog2(HOLD_CYC) bits), output registers.
// TESTING
//   1 Reset: hold rst=0 for 3 cycles with req_valid_i=4'hF
//     -> all outputs 0; the first issue after release goes to requester 0.
//   2 Single requester: req 2 held valid, data 32'hA5A5_0002
//     -> smp_valid_o pulses every 18 cycles (HOLD_CYC=16); smp_src_o=2; data matches.
//   3 Rotation: 4'hF held, data i = 32'h1000_000i
//     -> grants 0,1,2,3,0; one ready pulse per issue, coincident with smp_valid_o.
//   4 Wrap/skip: rr_ptr=3 (after serving req 2), valid=4'b0101
//     -> next grant 0, then 2; the pointer wraps 3->0 correctly.
//   5 Reset mid-HOLD: rst=0 at hold_cnt=7
//     -> busy_o=0 next cycle, rr_ptr=0, no spurious smp_valid_o after release.
//   6 BUSY_EN build: smp_busy_i=1 for 30 cycles after issue
//     -> the next smp_valid_o comes 2 cycles after smp_busy_i falls, not at cycle 18.

Source files
------------

// File: rtl/sampler_arb_pkg.sv
// Shared types and helpers for the sampler round-robin arbiter.
package sampler_arb_pkg;

    typedef enum logic [1:0] {
        ST_ARB_IDLE  = 2'd0,
        ST_ARB_ISSUE = 2'd1,
        ST_ARB_HOLD  = 2'd2
    } arb_state_e;

    // Index width for n requesters; never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational rotate-priority picker: first set request bit at or after ptr, wrapping.
module rr_prio_pick
    import sampler_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any_c,
    output logic [NUM_REQ-1:0] grant_c,
    output logic [IDX_W-1:0]   idx_c
);

    logic [IDX_W-1:0] pos;

    always_comb begin
        any_c   = 1'b0;
        grant_c = '0;
        idx_c   = '0;
        pos     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pos = IDX_W'((32'(ptr) + i) % NUM_REQ);
            if (!any_c && req[pos]) begin
                any_c        = 1'b1;
                grant_c[pos] = 1'b1;
                idx_c        = pos;
            end
        end
    end

endmodule

// File: rtl/sampler_rr_arbiter.sv
// Round-robin scheduler feeding one shared data_sampler CDC path: issue, then hold off.
// Optional build macro SAMPLER_ARB_BUSY_EN adds smp_busy_i to extend HOLD while the sampler is busy.
module sampler_rr_arbiter
    import sampler_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ  = 4,
    parameter  int unsigned DATA_W   = 32,
    parameter  int unsigned HOLD_CYC = 16,
    localparam int unsigned IDX_W    = idx_w(NUM_REQ)
) (
    input  logic                      fast_clk,
    input  logic                      rst,
`ifdef SAMPLER_ARB_BUSY_EN
    input  logic                      smp_busy_i,
`endif
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      smp_valid_o,
    output logic [DATA_W-1:0]         smp_data_o,
    output logic [IDX_W-1:0]          smp_src_o,
    output logic                      busy_o
);

    localparam int unsigned HW = $clog2(HOLD_CYC);

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr, ptr_d;
    logic [HW-1:0]        hold_cnt, cnt_d;
    logic [NUM_REQ-1:0]   ready_d;
    logic                 valid_d;
    logic [DATA_W-1:0]    data_d;
    logic [IDX_W-1:0]     src_d;
    logic                 busy_d;
    logic                 hold_done;

    logic                 pick_any;
    logic [NUM_REQ-1:0]   pick_grant;
    logic [IDX_W-1:0]     pick_idx;

    rr_prio_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (req_valid_i),
        .ptr     (rr_ptr),
        .any_c   (pick_any),
        .grant_c (pick_grant),
        .idx_c   (pick_idx)
    );

`ifdef SAMPLER_ARB_BUSY_EN
    assign hold_done = (hold_cnt == '0) && !smp_busy_i;
`else
    assign hold_done = (hold_cnt == '0);
`endif

    // Next-state and next-output logic; payload and source only move on IDLE->ISSUE.
    always_comb begin
        state_d = state_q;
        ptr_d   = rr_ptr;
        cnt_d   = hold_cnt;
        ready_d = '0;
        valid_d = 1'b0;
        data_d  = smp_data_o;
        src_d   = smp_src_o;
        busy_d  = busy_o;
        unique case (state_q)
            ST_ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ST_ARB_ISSUE;
                    ready_d = pick_grant;
                    valid_d = 1'b1;
                    src_d   = pick_idx;
                    busy_d  = 1'b1;
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (pick_grant[i]) begin
                            data_d = req_data_i[i*DATA_W +: DATA_W];
                        end
                    end
                end
            end
            ST_ARB_ISSUE: begin
                state_d = ST_ARB_HOLD;
                cnt_d   = HW'(HOLD_CYC - 1);
                ptr_d   = (32'(smp_src_o) == NUM_REQ - 1) ? '0 : smp_src_o + IDX_W'(1);
            end
            ST_ARB_HOLD: begin
                if (hold_done) begin
                    state_d = ST_ARB_IDLE;
                    busy_d  = 1'b0;
                end else if (hold_cnt != '0) begin
                    cnt_d = hold_cnt - HW'(1);
                end
            end
            default: begin
                state_d = ST_ARB_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge fast_clk) begin
        if (!rst) begin
            state_q     <= ST_ARB_IDLE;
            rr_ptr      <= '0;
            hold_cnt    <= '0;
            req_ready_o <= '0;
            smp_valid_o <= 1'b0;
            smp_data_o  <= '0;
            smp_src_o   <= '0;
            busy_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr      <= ptr_d;
            hold_cnt    <= cnt_d;
            req_ready_o <= ready_d;
            smp_valid_o <= valid_d;
            smp_data_o  <= data_d;
            smp_src_o   <= src_d;
            busy_o      <= busy_d;
        end
    end

endmodule

// File: tb/tb_sampler_rr_arbiter.sv
// Directed self-checking bench for sampler_rr_arbiter (NUM_REQ=4, DATA_W=32, HOLD_CYC=16).
module tb_sampler_rr_arbiter;

    localparam int unsigned NUM_REQ  = 4;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned HOLD_CYC = 16;

    logic                      fast_clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ*DATA_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic                      smp_valid_o;
    logic [DATA_W-1:0]         smp_data_o;
    logic [1:0]                smp_src_o;
    logic                      busy_o;
`ifdef SAMPLER_ARB_BUSY_EN
    logic                      smp_busy_i;
`endif

    int checks = 0;
    int errors = 0;

    sampler_rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .HOLD_CYC (HOLD_CYC)
    ) dut (
        .fast_clk    (fast_clk),
        .rst         (rst),
`ifdef SAMPLER_ARB_BUSY_EN
        .smp_busy_i  (smp_busy_i),
`endif
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_ready_o (req_ready_o),
        .smp_valid_o (smp_valid_o),
        .smp_data_o  (smp_data_o),
        .smp_src_o   (smp_src_o),
        .busy_o      (busy_o)
    );

    always #5 fast_clk = ~fast_clk;

    task automatic tick();
        @(negedge fast_clk);
    endtask

    task automatic load_data(input logic [DATA_W-1:0] base);
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data_i[i*DATA_W +: DATA_W] = base + DATA_W'(i);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        req_valid_i = '0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    // Advance until smp_valid_o is seen high or the budget runs out.
    task automatic wait_issue(input int max_cyc, output int n, output bit seen);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < max_cyc) begin
            tick();
            n++;
            if (smp_valid_o === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        int n; bit seen;
        rst         = 1'b0;
        req_valid_i = 4'hF;
        load_data(32'h1000_0000);
        repeat (3) tick();
        checks++;
        if ({req_ready_o, smp_valid_o, smp_data_o, smp_src_o, busy_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b valid=%b data=%h src=%0d busy=%b, required all 0",
                     req_ready_o, smp_valid_o, smp_data_o, smp_src_o, busy_o);
        end
        rst = 1'b1;
        wait_issue(4, n, seen);
        checks++;
        if (!seen || n != 1) begin
            errors++;
            $display("FAIL reset_first_issue_latency: seen=%b after %0d cycles, required seen after 1", seen, n);
        end
        checks++;
        if (smp_src_o !== 2'd0 || req_ready_o !== 4'b0001 || smp_data_o !== 32'h1000_0000 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: src=%0d ready=%b data=%h busy=%b, required 0 0001 10000000 1",
                     smp_src_o, req_ready_o, smp_data_o, busy_o);
        end
    endtask

    task automatic test_single_requester();
        int n; bit seen; int spurious;
        do_reset();
        load_data(32'h0);
        req_data_i[2*DATA_W +: DATA_W] = 32'hA5A5_0002;
        req_valid_i = 4'b0100;
        wait_issue(6, n, seen);
        checks++;
        if (!seen || smp_src_o !== 2'd2 || smp_data_o !== 32'hA5A5_0002 || req_ready_o !== 4'b0100) begin
            errors++;
            $display("FAIL single_first: seen=%b src=%0d data=%h ready=%b, required 1 2 a5a50002 0100",
                     seen, smp_src_o, smp_data_o, req_ready_o);
        end
        for (int p = 0; p < 2; p++) begin
            spurious = 0;
            for (int c = 1; c <= 16; c++) begin
                tick();
                if (smp_valid_o !== 1'b0 || req_ready_o !== 4'b0000 || busy_o !== 1'b1) spurious++;
            end
            checks++;
            if (spurious != 0) begin
                errors++;
                $display("FAIL single_hold_%0d: %0d bad hold cycles, required 0", p, spurious);
            end
            tick();
            checks++;
            if (busy_o !== 1'b0 || smp_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL single_idle_%0d: busy=%b valid=%b, required 0 0", p, busy_o, smp_valid_o);
            end
            tick();
            checks++;
            if (smp_valid_o !== 1'b1 || smp_src_o !== 2'd2 || smp_data_o !== 32'hA5A5_0002 || req_ready_o !== 4'b0100) begin
                errors++;
                $display("FAIL single_period_%0d: valid=%b src=%0d data=%h ready=%b at cycle 18, required 1 2 a5a50002 0100",
                         p, smp_valid_o, smp_src_o, smp_data_o, req_ready_o);
            end
        end
    endtask

    task automatic test_rotation();
        int n; bit seen;
        logic [3:0] exp_ready;
        do_reset();
        load_data(32'h1000_0000);
        req_valid_i = 4'hF;
        for (int k = 0; k < 5; k++) begin
            exp_ready = 4'b0001 << (k % 4);
            wait_issue(25, n, seen);
            checks++;
            if (!seen || 32'(smp_src_o) != (k % 4) || req_ready_o !== exp_ready
                || smp_data_o !== 32'h1000_0000 + 32'(k % 4)) begin
                errors++;
                $display("FAIL rotation_%0d: seen=%b src=%0d ready=%b data=%h, required src %0d ready %b",
                         k, seen, smp_src_o, req_ready_o, smp_data_o, k % 4, exp_ready);
            end
        end
    endtask

    task automatic test_wrap_skip();
        int n; bit seen;
        do_reset();
        load_data(32'h2000_0000);
        req_valid_i = 4'b0100;
        wait_issue(6, n, seen);
        checks++;
        if (!seen || smp_src_o !== 2'd2) begin
            errors++;
            $display("FAIL wrap_setup: seen=%b src=%0d, required 1 2", seen, smp_src_o);
        end
        tick();
        req_valid_i = 4'b0101;
        wait_issue(25, n, seen);
        checks++;
        if (!seen || smp_src_o !== 2'd0 || req_ready_o !== 4'b0001 || smp_data_o !== 32'h2000_0000) begin
            errors++;
            $display("FAIL wrap_to_0: seen=%b src=%0d ready=%b data=%h, required 1 0 0001 20000000",
                     seen, smp_src_o, req_ready_o, smp_data_o);
        end
        wait_issue(25, n, seen);
        checks++;
        if (!seen || smp_src_o !== 2'd2 || req_ready_o !== 4'b0100 || smp_data_o !== 32'h2000_0002) begin
            errors++;
            $display("FAIL wrap_skip_to_2: seen=%b src=%0d ready=%b data=%h, required 1 2 0100 20000002",
                     seen, smp_src_o, req_ready_o, smp_data_o);
        end
    endtask

    task automatic test_reset_mid_hold();
        int n; bit seen; int spurious;
        do_reset();
        load_data(32'h3000_0000);
        req_valid_i = 4'b0010;
        wait_issue(6, n, seen);
        checks++;
        if (!seen || smp_src_o !== 2'd1) begin
            errors++;
            $display("FAIL midhold_setup: seen=%b src=%0d, required 1 1", seen, smp_src_o);
        end
        repeat (9) tick();
        rst         = 1'b0;
        req_valid_i = '0;
        tick();
        checks++;
        if (busy_o !== 1'b0 || smp_valid_o !== 1'b0 || smp_src_o !== 2'd0 || smp_data_o !== 32'h0) begin
            errors++;
            $display("FAIL midhold_reset: busy=%b valid=%b src=%0d data=%h, required all 0",
                     busy_o, smp_valid_o, smp_src_o, smp_data_o);
        end
        rst = 1'b1;
        spurious = 0;
        repeat (20) begin
            tick();
            if (smp_valid_o !== 1'b0 || busy_o !== 1'b0) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL midhold_spurious: %0d cycles with activity, required 0", spurious);
        end
        req_valid_i = 4'hF;
        wait_issue(4, n, seen);
        checks++;
        if (!seen || smp_src_o !== 2'd0 || req_ready_o !== 4'b0001) begin
            errors++;
            $display("FAIL midhold_ptr_cleared: seen=%b src=%0d ready=%b, required 1 0 0001",
                     seen, smp_src_o, req_ready_o);
        end
    endtask

`ifdef SAMPLER_ARB_BUSY_EN
    task automatic test_busy_extend();
        int n; bit seen;
        smp_busy_i = 1'b0;
        do_reset();
        load_data(32'h4000_0000);
        req_valid_i = 4'b0001;
        wait_issue(6, n, seen);
        smp_busy_i = 1'b1;
        wait_issue(30, n, seen);
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL busy_early_issue: issue after %0d cycles while busy, required none", n);
        end
        smp_busy_i = 1'b0;
        wait_issue(6, n, seen);
        checks++;
        if (!seen || n != 2 || smp_src_o !== 2'd0) begin
            errors++;
            $display("FAIL busy_release: seen=%b after %0d cycles src=%0d, required seen after 2 src 0",
                     seen, n, smp_src_o);
        end
    endtask
`endif

    initial begin
        rst         = 1'b0;
        req_valid_i = '0;
        req_data_i  = '0;
`ifdef SAMPLER_ARB_BUSY_EN
        smp_busy_i  = 1'b0;
`endif
        test_reset();
        test_single_requester();
        test_rotation();
        test_wrap_skip();
        test_reset_mid_hold();
`ifdef SAMPLER_ARB_BUSY_EN
        test_busy_extend();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
